// File: rtl/switch_reader.sv
// switch_reader: synchronises and debounces 8 active-low switches, emits
// per-bit press/release pulses and queues each accepted edge as a 4-bit
// event code ({press, index}) in a small show-ahead FIFO.
module switch_reader #(
  parameter int unsigned CLK_HZ         = 12090000,
  parameter int unsigned TICK_HZ        = 1000,
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_n,
  output logic [7:0] sw_level,
  output logic [7:0] press_pulse,
  output logic [7:0] release_pulse,
  output logic       evt_valid,
  output logic [3:0] evt_data,
  input  logic       evt_ready,
  output logic       overflow
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W   = $clog2(TICK_DIV);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [TICK_W-1:0] TICK_LAST     = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        DB_LAST       = 8'(DEBOUNCE_TICKS - 1);
  localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  logic [7:0]        sync1;
  logic [7:0]        sync2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic [7:0]        db_cnt [8];

  logic [7:0]        pend_valid;
  logic [7:0]        pend_type;
  logic [2:0]        grant_idx;
  logic              any_pend;
  logic              push;
  logic [7:0]        grant_vec;

  logic [3:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;
  logic              pop;

  // Two-flop synchroniser on the inverted pins; reset means "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~sw_n;
      sync2 <= sync1;
    end
  end

  // Free-running sample-rate divider; tick marks its last count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Per-bit debounce: a change is accepted after consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_level      <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int i = 0; i < 8; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (tick) begin
        for (int i = 0; i < 8; i++) begin
          if (sync2[i] == sw_level[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DB_LAST) begin
            sw_level[i]      <= sync2[i];
            db_cnt[i]        <= '0;
            press_pulse[i]   <= sync2[i];
            release_pulse[i] <= ~sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Lowest-index pending entry wins; it is written only if the FIFO has room.
  always_comb begin
    grant_idx = 3'd0;
    any_pend  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_valid[i]) begin
        grant_idx = 3'(i);
        any_pend  = 1'b1;
      end
    end
    push      = any_pend && !fifo_full;
    grant_vec = '0;
    if (push) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // Pending slots; an opposite edge arriving on an unsent entry cancels both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= '0;
      pend_type  <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (press_pulse[i] || release_pulse[i]) begin
          if (pend_valid[i] && !grant_vec[i]) begin
            pend_valid[i] <= 1'b0;
            overflow      <= 1'b1;
          end else begin
            pend_valid[i] <= 1'b1;
            pend_type[i]  <= press_pulse[i];
          end
        end else if (grant_vec[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign fifo_full = (count == FIFO_FULL_CNT);
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;

  // FIFO pointers and occupancy; full is judged before this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pend_type[grant_idx], grant_idx};
    end
  end

  // Show-ahead head, forced to zero while empty.
  always_comb begin
    evt_data = 4'h0;
    if (evt_valid) begin
      evt_data = fifo_mem[rd_ptr];
    end
  end

endmodule
